cory_debounce: RTL and testbench

CORY_DEBOUNCE -- requirements
Module: cory_debounce

---
 rtl/cory_debounce_pkg.sv | 14 +
 rtl/cory_sync.sv | 25 ++
 rtl/cory_debounce.sv | 100 ++++++++++
 tb/tb_cory_debounce.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cory_debounce_pkg.sv
// Shared constants for the debounce slice.
// Synchronizer depth bounds and the clamp used by cory_sync.
package cory_debounce_pkg;

  localparam int N_SYNC_MIN = 2;
  localparam int N_SYNC_MAX = 4;

  function automatic int sync_depth(input int n);
    if (n < N_SYNC_MIN) return N_SYNC_MIN;
    if (n > N_SYNC_MAX) return N_SYNC_MAX;
    return n;
  endfunction

endpackage

// File: rtl/cory_sync.sv
// Plain flop-chain synchronizer for an asynchronous level.
// Depth is N_SYNC, held inside the 2..4 range.
module cory_sync
  import cory_debounce_pkg::*;
#(
  parameter int N_SYNC = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_a,
  output logic o_z
);

  localparam int DEPTH = sync_depth(N_SYNC);

  logic [DEPTH-1:0] q;

  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= {q[DEPTH-2:0], i_a};
  end

  assign o_z = q[DEPTH-1];

endmodule

// File: rtl/cory_debounce.sv
// Synchronize then qualify a level for i_period+1 cycles.
// o_z and o_busy are raw state bits, so they never glitch.
module cory_debounce
  import cory_debounce_pkg::*;
#(
  parameter int N_SYNC = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_a,
  input  logic [CNT_W-1:0] i_period,
  output logic             o_z,
  output logic             o_busy,
  output logic             o_glitch
);

  // bit1 = debounced level, bit0 = qualifying
  typedef enum logic [1:0] {
    LO    = 2'b00,
    LO2HI = 2'b01,
    HI    = 2'b10,
    HI2LO = 2'b11
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             glitch_q, glitch_n;
  logic             s;

  cory_sync #(
    .N_SYNC(N_SYNC)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .i_a  (i_a),
    .o_z  (s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= LO;
      cnt      <= '0;
      glitch_q <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      glitch_q <= glitch_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    glitch_n = 1'b0;
    unique case (state)
      LO: begin
        if (s) begin
          state_n = LO2HI;
          cnt_n   = '0;
        end
      end
      LO2HI: begin
        if (!s) begin
          state_n  = LO;
          cnt_n    = '0;
          glitch_n = 1'b1;
        end else if (cnt >= i_period) begin
          state_n = HI;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HI: begin
        if (!s) begin
          state_n = HI2LO;
          cnt_n   = '0;
        end
      end
      HI2LO: begin
        if (s) begin
          state_n  = HI;
          cnt_n    = '0;
          glitch_n = 1'b1;
        end else if (cnt >= i_period) begin
          state_n = LO;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
    endcase
  end

  assign o_z      = state[1];
  assign o_busy   = state[0];
  assign o_glitch = glitch_q;

endmodule

// File: tb/tb_cory_debounce.sv
// Bench for cory_debounce: directed latency cases plus a
// run-length reference model checked every cycle.
module tb_cory_debounce;

  localparam int N_SYNC = 2;
  localparam int CNT_W  = 16;

  logic             clk;
  logic             reset;
  logic             i_a;
  logic [CNT_W-1:0] i_period;
  logic             o_z;
  logic             o_busy;
  logic             o_glitch;

  int checks   = 0;
  int failures = 0;

  cory_debounce #(
    .N_SYNC(N_SYNC),
    .CNT_W (CNT_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_a     (i_a),
    .i_period(i_period),
    .o_z     (o_z),
    .o_busy  (o_busy),
    .o_glitch(o_glitch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference: s is i_a delayed N_SYNC edges; o_z flips once s has
  // disagreed with it on run edges with run-2 >= i_period.
  logic sh [N_SYNC];
  int   run     = 0;
  logic mz      = 1'b0;
  logic mg      = 1'b0;
  logic mb      = 1'b0;
  bit   started = 1'b0;

  always @(posedge clk) begin
    logic ms;
    if (reset) begin
      for (int i = 0; i < N_SYNC; i++) sh[i] = 1'b0;
      run = 0;
      mz  = 1'b0;
      mg  = 1'b0;
    end else begin
      ms = sh[N_SYNC-1];
      for (int i = N_SYNC-1; i > 0; i--) sh[i] = sh[i-1];
      sh[0] = i_a;
      mg = 1'b0;
      if (ms != mz) begin
        run++;
        if (run >= 2 && run - 2 >= int'(i_period)) begin
          mz  = ~mz;
          run = 0;
        end
      end else begin
        mg  = (run > 0);
        run = 0;
      end
    end
    mb = (run > 0);
    started = 1'b1;
    #1;
    if (started) begin
      chk("model_z", int'(o_z), int'(mz));
      chk("model_busy", int'(o_busy), int'(mb));
      chk("model_glitch", int'(o_glitch), int'(mg));
    end
  end

  // k = edges after the capturing edge until o_z == lvl
  task automatic wait_z(input logic lvl, input int max,
                        output int k, output int nb, output int ng);
    k  = 0;
    nb = 0;
    ng = 0;
    forever begin
      @(posedge clk);
      #1;
      nb += int'(o_busy);
      ng += int'(o_glitch);
      if (o_z == lvl) break;
      k++;
      if (k > max) begin
        $display("FAIL wait_z timeout actual=%0d required=%0d", k, max);
        break;
      end
    end
  endtask

  initial begin
    int k, nb, ng, zs, bag;
    reset    = 1'b1;
    i_a      = 1'b1;
    i_period = 16'd4;

    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_z", int'(o_z), 0);
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_glitch", int'(o_glitch), 0);
    end
    @(negedge clk);
    reset = 1'b0;
    wait_z(1'b1, 100, k, nb, ng);
    chk("post_rst_rise", k, 7);

    @(negedge clk);
    i_a = 1'b0;
    wait_z(1'b0, 100, k, nb, ng);
    chk("fall_lat_p4", k, 7);
    chk("fall_busy_p4", nb, 5);
    repeat (20) @(negedge clk);
    i_a = 1'b1;
    wait_z(1'b1, 100, k, nb, ng);
    chk("rise_lat_p4", k, 7);
    chk("rise_busy_p4", nb, 5);
    chk("rise_glitch_p4", ng, 0);
    repeat (20) @(negedge clk);
    i_a = 1'b0;
    wait_z(1'b0, 100, k, nb, ng);
    chk("fall2_lat_p4", k, 7);
    repeat (5) @(negedge clk);

    // three-cycle pulse must be rejected
    i_a = 1'b1;
    zs  = 0;
    ng  = 0;
    nb  = 0;
    bag = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      zs += int'(o_z);
      nb += int'(o_busy);
      ng += int'(o_glitch);
      if (o_glitch) bag += int'(o_busy);
      if (c == 2) i_a = 1'b0;
    end
    chk("pulse_z", zs, 0);
    chk("pulse_glitch", ng, 1);
    chk("pulse_busy", nb, 3);
    chk("pulse_busy_at_glitch", bag, 0);

    @(negedge clk);
    i_period = 16'd0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      i_a = ~i_a;
      wait_z(i_a, 50, k, nb, ng);
      chk("p0_lat", k, 3);
      chk("p0_glitch", ng, 0);
    end
    repeat (5) @(negedge clk);
    i_a = 1'b0;
    wait_z(1'b0, 50, k, nb, ng);
    repeat (5) @(negedge clk);

    // shrink the period mid-check
    i_period = 16'd10;
    i_a = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("shrink_z_before", int'(o_z), 0);
    chk("shrink_busy_before", int'(o_busy), 1);
    @(negedge clk);
    i_period = 16'd2;
    @(posedge clk);
    #1;
    chk("shrink_z_after", int'(o_z), 1);

    // reset in the middle of LO2HI
    @(negedge clk);
    i_period = 16'd8;
    i_a = 1'b0;
    wait_z(1'b0, 100, k, nb, ng);
    chk("p8_fall_lat", k, 11);
    @(negedge clk);
    i_a = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    chk("mid_busy", int'(o_busy), 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_z", int'(o_z), 0);
    chk("mid_rst_busy", int'(o_busy), 0);
    chk("mid_rst_glitch", int'(o_glitch), 0);
    @(negedge clk);
    reset = 1'b0;
    wait_z(1'b1, 100, k, nb, ng);
    chk("mid_rst_rise", k, 11);

    // random runs, period changes and resets against the model
    for (int r = 0; r < 300; r++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0)
        i_period = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
      i_a = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 11)) @(negedge clk);
    end
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
